seg_scan_drv: RTL and testbench
===============================

Name: seg_scan_drv

Overview:
- Display-side consumer of the 24-bit packed temperature digit word and the alarm flag produced by the temperature formatter.
- Time-multiplexes six common-anode 7-segment digits and decodes each nibble to segments, including sign code, decimal point and leading-zero blanking.
- Blinks the whole display while the alarm flag is set.
- Latches input once per frame so digits never tear mid-scan.

Parameters:
- SCAN_CNT, 50000, sys_clk cycles per digit slot (1 ms at 50 MHz); minimum 2.
- BLINK_FRM, 42, frames per blink half-period (~250 ms at default); minimum 1.

Ports:
- sys_clk  in  1  system clock, all logic rising-edge.
- sys_rst  in  1  asynchronous, active-high reset.
- dis_data  in  24  packed digits {sign,tens,units,0.1,0.01,0.001}, 4 bits each, MSB nibble = sign.
- en  in  1  alarm flag; 1 = blink display.
- sel  out  6  digit enables, active-low; sel[0] = rightmost digit (dis_data[3:0]), sel[5] = sign digit.
- seg  out  8  segments, active-low; seg[7] = dp, seg[6:0] = g..a.

Behaviour:
- Reset (async, immediate, also mid-scan):
  - sel = 6'h3F, seg = 8'hFF.
  - Tick counter, digit index, frame counter and blink phase = 0.
  - Shadow data = 24'hAFFFFF, shadow en = 0, i.e. blank display.
- Tick counter:
  - Counts 0..SCAN_CNT-1 and wraps.
  - scan_tick is a one-cycle pulse when the counter equals SCAN_CNT-1.
- Digit index idx:
  - Runs 0..5 and advances on scan_tick; 5 -> 0 wraps.
  - frame_end = scan_tick and idx == 5.
- Shadow capture on frame_end:
  - Load dis_data and en into shadow registers.
  - Values take effect from idx 0 of the next frame; changes mid-frame are invisible.
- Blink:
  - Frame counter increments on frame_end and wraps at BLINK_FRM-1.
  - On that wrap, blink_phase toggles.
  - When shadow en = 0, blink_phase is held at 0 and the frame counter is cleared.
- Nibble select: nib = shadow[4*idx+3 : 4*idx].
- Segment decode (7-bit g..a, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - B (minus) = 3F.
  - A (plus) and C..F = 7F (blank).
- Leading-zero blanking: idx == 4 and nib == 0 -> blank.
- Decimal point: seg[7] = 0 only when idx == 3 (units digit); otherwise 1.
- Blink gating: shadow en = 1 and blink_phase = 1 -> sel = 6'h3F, seg = 8'hFF.
- Normal output: sel = ~(6'b1 << idx); seg = {dp_n, decoded}.
- Output timing:
  - sel and seg are registered, updating the cycle after idx changes (1-cycle latency).
  - No cycle exists with two digits enabled.
- Latency: a dis_data change reaches the display within 1 frame + 1 slot + 1 cycle of the next frame_end.
- Simultaneous events:
  - frame_end with the blink wrap: shadow load and phase toggle occur in the same cycle.
  - en falling at frame_end: after that load, shadow en = 0, so blink stops at the next frame.

Test Plan:
- Reset:
  - Assert sys_rst mid-scan -> sel = 3F and seg = FF in the same cycle.
  - After release with dis_data = 0, first frame blank (sel walks, seg = FF except dp slot 7F); from second frame digits show "0.000" with tens blank.
- Positive value, SCAN_CNT = 4, dis_data = 24'hA25062, en = 0 -> second frame slots idx0..5 give:
  - sel = 3E/3D/3B/37/2F/1F.
  - seg = A4/82/C0/12/A4/FF.
- Negative single digit, dis_data = 24'hB05000 -> idx3 seg = 12, idx4 seg = FF (blanked zero), idx5 seg = BF.
- Anti-tear: change dis_data from 24'hA25062 to 24'hA31000 while idx = 2 -> idx3..5 still show 12/A4/FF; new digits appear only from the frame after frame_end.
- Blink, BLINK_FRM = 2, en = 1 held:
  - Display alternates: 2 frames lit, then 2 frames with sel = 3F and seg = FF.
  - Drop en -> display stays lit from the frame after the next frame_end.
- Wrap/boundary, SCAN_CNT = 2:
  - idx 5 -> 0 wrap occurs every 12 cycles.
  - No cycle has more than one sel bit low, checked by assertion.

Source files
------------

// File: rtl/seg_scan_drv.sv
// Six-digit common-anode 7-segment scanner: frame-latched digit word, per-digit
// decode with sign, decimal point, leading-zero blanking and alarm blink.
module seg_scan_drv #(
  parameter int SCAN_CNT  = 50000,
  parameter int BLINK_FRM = 42
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [23:0] dis_data,
  input  logic        en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int TW = $clog2(SCAN_CNT);
  localparam int FW = (BLINK_FRM > 1) ? $clog2(BLINK_FRM) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_CNT - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRM - 1);
  localparam logic [23:0]   BLANK_WORD = 24'hAFFFFF;

  logic [TW-1:0] tick_cnt;
  logic [2:0]    idx;
  logic [FW-1:0] frm_cnt;
  logic          blink_phase;
  logic [23:0]   sh_data;
  logic          sh_en;

  logic       scan_tick;
  logic       frame_end;
  logic [3:0] nib;
  logic [6:0] dec;
  logic       dp_n;
  logic [5:0] sel_d;
  logic [7:0] seg_d;

  assign scan_tick = (tick_cnt == TICK_LAST);
  assign frame_end = scan_tick && (idx == 3'd5);

  // NOTE: async reset in the sensitivity list; all state uses non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tick_cnt <= '0;
      idx      <= '0;
    end else begin
      tick_cnt <= scan_tick ? '0 : tick_cnt + 1'b1;
      if (scan_tick) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
  end

  // Shadow copy only moves at frame boundaries so a scan never mixes two words.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_data <= BLANK_WORD;
      sh_en   <= 1'b0;
    end else if (frame_end) begin
      sh_data <= dis_data;
      sh_en   <= en;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (!sh_en) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frm_cnt == FRM_LAST) begin
        frm_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    nib = 4'h0;
    case (idx)
      3'd0:    nib = sh_data[3:0];
      3'd1:    nib = sh_data[7:4];
      3'd2:    nib = sh_data[11:8];
      3'd3:    nib = sh_data[15:12];
      3'd4:    nib = sh_data[19:16];
      3'd5:    nib = sh_data[23:20];
      default: nib = 4'hF;
    endcase

    dec = 7'h7F;
    case (nib)
      4'h0:    dec = 7'h40;
      4'h1:    dec = 7'h79;
      4'h2:    dec = 7'h24;
      4'h3:    dec = 7'h30;
      4'h4:    dec = 7'h19;
      4'h5:    dec = 7'h12;
      4'h6:    dec = 7'h02;
      4'h7:    dec = 7'h78;
      4'h8:    dec = 7'h00;
      4'h9:    dec = 7'h10;
      4'hB:    dec = 7'h3F;
      default: dec = 7'h7F;
    endcase
    // A zero in the tens position is suppressed; units always shows.
    if (idx == 3'd4 && nib == 4'h0) dec = 7'h7F;

    dp_n  = (idx != 3'd3);
    sel_d = 6'h3F;
    seg_d = 8'hFF;
    if (!(sh_en && blink_phase)) begin
      sel_d = ~(6'b1 << idx);
      seg_d = {dp_n, dec};
    end
  end

  // Registered drive: one-cycle latency from idx, and a single enable per cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel <= 6'h3F;
      seg <= 8'hFF;
    end else begin
      sel <= sel_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Self-checking bench for seg_scan_drv: directed frames plus randomized data/alarm
// traffic compared every cycle against a frame-level reference model.
module tb_seg_scan_drv;

  localparam int S     = 4;
  localparam int B     = 2;
  localparam int FRAME = 6 * S;

  typedef struct packed {
    logic [23:0] d;
    logic        e;
  } shadow_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [23:0] dis_data;
  logic        en;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic [5:0]  sel2;
  logic [7:0]  seg2;

  int vectors     = 0;
  int miscompares = 0;
  int c           = 0;
  shadow_t fq[$];

  seg_scan_drv #(.SCAN_CNT(S), .BLINK_FRM(B)) u_dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .dis_data(dis_data),
    .en      (en),
    .sel     (sel),
    .seg     (seg)
  );

  seg_scan_drv #(.SCAN_CNT(2), .BLINK_FRM(1)) u_dut_fast (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .dis_data(dis_data),
    .en      (1'b0),
    .sel     (sel2),
    .seg     (seg2)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hB: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Display after `cyc` clock edges: the output reflects frame/slot of the prior cycle.
  function automatic logic [13:0] model_out(input int cyc);
    int fr, slot, s, phase;
    logic [3:0] nib;
    logic [6:0] d7;
    if (cyc == 0) return {6'h3F, 8'hFF};
    fr   = (cyc - 1) / FRAME;
    slot = ((cyc - 1) / S) % 6;
    if (fq[fr].e) begin
      s = fr;
      while (s > 0 && fq[s-1].e) s--;
      phase = ((fr - s) / B) % 2;
      if (phase == 1) return {6'h3F, 8'hFF};
    end
    nib = 4'((fq[fr].d >> (4 * slot)) & 24'hF);
    d7  = (slot == 4 && nib == 4'h0) ? 7'h7F : seg7(nib);
    return {~(6'b1 << slot), (slot == 3) ? 1'b0 : 1'b1, d7};
  endfunction

  // Reference bookkeeping: cycle count since reset and the word latched per frame.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      c <= 0;
      fq.delete();
      fq.push_back({24'hAFFFFF, 1'b0});
    end else begin
      if (c % FRAME == FRAME - 1) fq.push_back({dis_data, en});
      c <= c + 1;
    end
  end

  logic [13:0] exp_out;
  int   last_idx0 = -1;
  logic [5:0] prev_sel2 = 6'h3F;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      last_idx0 = -1;
      prev_sel2 = 6'h3F;
    end else begin
      if (c > 0 && (c - 1) / FRAME >= fq.size()) begin
        check("model_frame_range", fq.size(), (c - 1) / FRAME + 1);
      end else begin
        exp_out = model_out(c);
        check("sel", sel, exp_out[13:8]);
        check("seg", seg, exp_out[7:0]);
      end
      check("sel_onehot", $countones(~sel) <= 1, 1);
      check("sel2_onehot", $countones(~sel2) <= 1, 1);
      if (sel2 == 6'h3E && prev_sel2 != 6'h3E) begin
        if (last_idx0 >= 0) check("wrap_period", c - last_idx0, 12);
        last_idx0 = c;
      end
      prev_sel2 = sel2;
    end
  end

  task automatic check_slot(input string tag, input int fr, input int i,
                            input logic [5:0] sel_e, input logic [7:0] seg_e);
    int target, n;
    target = fr * FRAME + i * S + 1;
    n = 0;
    while (c != target && n < 4 * FRAME) begin
      @(negedge sys_clk);
      n++;
    end
    if (c != target) begin
      check({tag, "_reach"}, c, target);
    end else begin
      check({tag, "_sel"}, sel, sel_e);
      check({tag, "_seg"}, seg, seg_e);
    end
  endtask

  task automatic random_run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge sys_clk);
      if ($urandom_range(0, 15) == 0) dis_data = 24'($urandom);
      if ($urandom_range(0, 60) == 0) en = ~en;
    end
  endtask

  initial begin
    dis_data = 24'h0;
    en       = 1'b0;
    sys_rst  = 1'b0;
    #1 sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("reset_sel", sel, 6'h3F);
    check("reset_seg", seg, 8'hFF);
    sys_rst = 1'b0;

    // First frame shows the blank reset word, then zeros.
    check_slot("f0_i0", 0, 0, 6'h3E, 8'hFF);
    check_slot("f0_i3", 0, 3, 6'h37, 8'h7F);
    check_slot("f0_i5", 0, 5, 6'h1F, 8'hFF);
    check_slot("f1_i0", 1, 0, 6'h3E, 8'hC0);
    check_slot("f1_i3", 1, 3, 6'h37, 8'h40);
    check_slot("f1_i4", 1, 4, 6'h2F, 8'hFF);
    dis_data = 24'hA25062;

    check_slot("f2_i0", 2, 0, 6'h3E, 8'hA4);
    check_slot("f2_i1", 2, 1, 6'h3D, 8'h82);
    check_slot("f2_i2", 2, 2, 6'h3B, 8'hC0);
    dis_data = 24'hA31000;
    check_slot("f2_i3", 2, 3, 6'h37, 8'h12);
    check_slot("f2_i4", 2, 4, 6'h2F, 8'hA4);
    check_slot("f2_i5", 2, 5, 6'h1F, 8'hFF);
    check_slot("f3_i3", 3, 3, 6'h37, 8'h79);
    dis_data = 24'hB05000;

    check_slot("f4_i3", 4, 3, 6'h37, 8'h12);
    check_slot("f4_i4", 4, 4, 6'h2F, 8'hFF);
    check_slot("f4_i5", 4, 5, 6'h1F, 8'hBF);
    en = 1'b1;

    check_slot("blink_f5", 5, 3, 6'h37, 8'h12);
    check_slot("blink_f6", 6, 0, 6'h3E, 8'hC0);
    check_slot("blink_f7", 7, 0, 6'h3F, 8'hFF);
    check_slot("blink_f8", 8, 5, 6'h3F, 8'hFF);
    check_slot("blink_f9", 9, 0, 6'h3E, 8'hC0);
    en = 1'b0;
    check_slot("unblink_f10", 10, 0, 6'h3E, 8'hC0);
    check_slot("unblink_f11", 11, 3, 6'h37, 8'h12);

    random_run(2400);

    // Settle into a lit display, then hit reset between clock edges.
    en = 1'b0;
    repeat (3 * FRAME) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    check("midscan_rst_sel", sel, 6'h3F);
    check("midscan_rst_seg", seg, 8'hFF);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    random_run(1600);
    @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
